// File: rtl/ita_mask_unit.sv
// ita_mask_unit: tiled attention-mask beat generator with ready/valid output
module ita_mask_unit #(
  parameter int N = 16,
  parameter int M = 64,
  parameter int WI = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [2:0]    mode_i,
  input  logic [WI-1:0] offset_i,
  input  logic [3:0]    stride_log2_i,
  input  logic [WI-1:0] tile_s_i,
  input  logic [WI-1:0] tile_r_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [N-1:0]  mask_o,
  output logic [WI-1:0] row_o,
  output logic [WI-1:0] col_o,
  output logic          busy_o,
  output logic          done_o
);
  localparam int BEATS = M * M / N;
  localparam int BW = $clog2(BEATS);
  localparam int MW = $clog2(M);
  localparam int NW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [2:0] mode;
  logic [WI-1:0] offset, ts, tr, tx, ty, ntx, nty, nrow, ncol, m_off, m_row, m_col;
  logic [3:0] stride, m_sl;
  logic [2:0] m_mode;
  logic [BW-1:0] b, nb;
  logic [N-1:0] nmask;
  logic go, wrap, tx_end, nlast;
  function automatic logic [N-1:0] mask_f(input logic [2:0] md, input logic [WI-1:0] o,
                                          input logic [3:0] sl, input logic [WI-1:0] rw,
                                          input logic [WI-1:0] cl);
    logic signed [WI+1:0] r, w, c, d;
    logic [WI+1:0] sm;
    logic st, win;
    logic [N-1:0] m;
    r = $signed({2'b00, rw});
    w = $signed({2'b00, o});
    sm = ~({(WI+2){1'b1}} << sl);
    m = '0;
    for (int i = 0; i < N; i++) begin
      c = $signed({2'b00, cl}) + (WI+2)'(i);
      d = c - r;
      st = (d & sm) != '0;
      win = (c > r - w) && (c < r + w);
      m[i] = md == 3'd1 ? c > r + w :
             md == 3'd2 ? c < r - w :
             md == 3'd3 ? st :
             md == 3'd4 ? st || c < r :
             md == 3'd5 ? st || c > r :
             md == 3'd6 ? !win :
             md == 3'd7 ? st && !win : 1'b0;
    end
    return m;
  endfunction
  always_comb begin
    go = state == IDLE && start_i;
    wrap = b == BW'(BEATS - 1);
    tx_end = tx == ts - 1'b1;
    nb = b + 1'b1;
    ntx = wrap ? (tx_end ? '0 : tx + 1'b1) : tx;
    nty = wrap && tx_end ? ty + 1'b1 : ty;
    nlast = nb == BW'(BEATS - 1) && ntx == ts - 1'b1 && nty == tr - 1'b1;
    nrow = (nty << MW) + WI'(nb & BW'(M - 1));
    ncol = (ntx << MW) + (WI'(nb >> MW) << NW);
    m_mode = go ? mode_i : mode;
    m_off = go ? offset_i : offset;
    m_sl = go ? stride_log2_i : stride;
    m_row = go ? '0 : nrow;
    m_col = go ? '0 : ncol;
    nmask = mask_f(m_mode, m_off, m_sl, m_row, m_col);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      valid_o <= 1'b0;
      mask_o <= '0;
      row_o <= '0;
      col_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      b <= '0;
      tx <= '0;
      ty <= '0;
      mode <= '0;
      offset <= '0;
      stride <= '0;
      ts <= '0;
      tr <= '0;
    end else if (abort_i) begin
      state <= IDLE;
      valid_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      b <= '0;
      tx <= '0;
      ty <= '0;
    end else begin
      done_o <= 1'b0;
      if (go) begin
        mode <= mode_i;
        offset <= offset_i;
        stride <= stride_log2_i;
        ts <= tile_s_i;
        tr <= tile_r_i;
        b <= '0;
        tx <= '0;
        ty <= '0;
        if (tile_s_i == '0 || tile_r_i == '0) begin
          done_o <= 1'b1;
        end else begin
          state <= RUN;
          valid_o <= 1'b1;
          busy_o <= 1'b1;
          mask_o <= nmask;
          row_o <= '0;
          col_o <= '0;
        end
      end else if (valid_o && ready_i) begin
        if (state == DRAIN) begin
          state <= IDLE;
          valid_o <= 1'b0;
          busy_o <= 1'b0;
          done_o <= 1'b1;
          b <= '0;
          tx <= '0;
          ty <= '0;
        end else begin
          state <= nlast ? DRAIN : RUN;
          b <= nb;
          tx <= ntx;
          ty <= nty;
          mask_o <= nmask;
          row_o <= nrow;
          col_o <= ncol;
        end
      end
    end
  end
endmodule

// File: tb/tb_ita_mask_unit.sv
// tb_ita_mask_unit: scoreboard bench for ita_mask_unit with directed jobs
module tb_ita_mask_unit;
  logic clk = 0, rst = 1, start = 0, abort = 0, ready = 1;
  logic [2:0] mode = 0;
  logic [15:0] offset = 0, ts = 0, tr = 0;
  logic [3:0] sl = 0;
  logic valid, busy, done;
  logic [15:0] mask, row, col;
  typedef struct packed {logic [15:0] row, col, mask;} beat_t;
  beat_t q[$];
  logic [15:0] cap_mask[int], cap_row[int], cap_col[int];
  int errors = 0, checks = 0, beats = 0, dones = 0, valids = 0;
  bit exp_done = 0;
  logic [15:0] hm, hr;
  always #5 clk = ~clk;
  ita_mask_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .mode_i(mode),
    .offset_i(offset), .stride_log2_i(sl), .tile_s_i(ts), .tile_r_i(tr),
    .valid_o(valid), .ready_i(ready), .mask_o(mask), .row_o(row), .col_o(col),
    .busy_o(busy), .done_o(done)
  );
  function automatic logic [15:0] model(int md, int off, int s, int r, int c0);
    logic [15:0] m = 0;
    for (int i = 0; i < 16; i++) begin
      int c, d;
      bit st, win;
      c = c0 + i;
      d = c - r;
      st = (((d % s) + s) % s) != 0;
      win = (c >= r - off + 1) && (c < r + off);
      case (md)
        1: m[i] = c > r + off;
        2: m[i] = c < r - off;
        3: m[i] = st;
        4: m[i] = st || c < r;
        5: m[i] = st || c > r;
        6: m[i] = !win;
        7: m[i] = st && !win;
        default: m[i] = 0;
      endcase
    end
    return m;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    beat_t e;
    if (exp_done) begin
      chk("done_pulse", done, 1);
      chk("busy_at_done", busy, 0);
      exp_done = 0;
    end
    if (done) dones++;
    if (valid) valids++;
    if (valid && ready && !abort && !rst) begin
      chk("beat_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("row", row, e.row);
        chk("col", col, e.col);
        chk("mask", mask, e.mask);
        chk("busy_in_run", busy, 1);
        cap_mask[beats] = mask;
        cap_row[beats] = row;
        cap_col[beats] = col;
        beats++;
        if (q.size() == 0) exp_done = 1;
      end
    end
    @(negedge clk);
  endtask
  task automatic start_job(int md, int off, int s, int tsn, int trn);
    mode = 3'(md); offset = 16'(off); sl = 4'(s); ts = 16'(tsn); tr = 16'(trn);
    beats = 0; dones = 0; valids = 0;
    cap_mask.delete(); cap_row.delete(); cap_col.delete();
    for (int y = 0; y < trn; y++)
      for (int x = 0; x < tsn; x++)
        for (int k = 0; k < 256; k++) begin
          int r, c;
          r = y * 64 + k % 64;
          c = x * 64 + (k / 64) * 16;
          q.push_back({16'(r), 16'(c), model(md, off, 1 << s, r, c)});
        end
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_done(int limit);
    int n = 0;
    while (dones == 0 && n < limit) begin
      tick();
      n++;
    end
    chk("job_completes", dones > 0, 1);
  endtask
  task automatic run_until(int k);
    int n = 0;
    while (beats < k && n < 500) begin
      tick();
      n++;
    end
    chk("reach_beat", beats, k);
  endtask
  initial begin
    @(negedge clk);
    tick();
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", mask, 0);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    rst = 0;
    tick();
    start_job(1, 0, 0, 1, 1);
    chk("first_valid", valid, 1);
    chk("busy_after_start", busy, 1);
    wait_done(400);
    chk("a_beats", beats, 256);
    chk("a_dones", dones, 1);
    chk("a_b0_mask", cap_mask[0], 16'hFFFE);
    chk("a_b0_row", cap_row[0], 0);
    chk("a_b0_col", cap_col[0], 0);
    chk("a_b64_col", cap_col[64], 16);
    chk("a_b64_mask", cap_mask[64], 16'hFFFF);
    start_job(2, 0, 0, 1, 1);
    wait_done(400);
    chk("b_b0_mask", cap_mask[0], 16'h0000);
    chk("b_b5_row", cap_row[5], 5);
    chk("b_b5_mask", cap_mask[5], 16'h001F);
    start_job(3, 0, 2, 1, 1);
    wait_done(400);
    chk("c_b0_mask", cap_mask[0], 16'hEEEE);
    chk("c_b1_mask", cap_mask[1], 16'hDDDD);
    start_job(6, 2, 0, 1, 1);
    wait_done(400);
    chk("d_b0_mask", cap_mask[0], 16'hFFFC);
    start_job(6, 0, 0, 1, 1);
    wait_done(400);
    chk("w0_b0_mask", cap_mask[0], 16'hFFFF);
    start_job(4, 0, 1, 1, 1);
    run_until(5);
    mode = 6; offset = 99; ts = 5; sl = 3; start = 1;
    tick();
    start = 0;
    wait_done(400);
    chk("e_beats", beats, 256);
    chk("e_dones", dones, 1);
    start_job(5, 3, 2, 1, 1);
    wait_done(400);
    start_job(7, 5, 3, 1, 1);
    wait_done(400);
    start_job(1, 7, 0, 1, 1);
    wait_done(400);
    start_job(2, 9, 0, 1, 1);
    wait_done(400);
    start_job(1, 0, 0, 1, 1);
    run_until(10);
    ready = 0;
    hm = mask;
    hr = row;
    chk("bp_row", hr, 10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", valid, 1);
      chk("bp_mask_hold", mask, hm);
      chk("bp_row_hold", row, hr);
    end
    ready = 1;
    tick();
    chk("bp_next_row", row, 11);
    wait_done(400);
    chk("bp_beats", beats, 256);
    start_job(0, 0, 0, 2, 2);
    wait_done(1200);
    chk("t_beats", beats, 1024);
    chk("t_b256_row", cap_row[256], 0);
    chk("t_b256_col", cap_col[256], 64);
    chk("t_b512_row", cap_row[512], 64);
    chk("t_b512_col", cap_col[512], 0);
    for (int i = 0; i < 3; i++) tick();
    chk("t_single_done", dones, 1);
    start_job(1, 0, 0, 0, 1);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("z_valids", valids, 0);
    chk("z_dones", dones, 1);
    start_job(1, 0, 0, 1, 1);
    run_until(20);
    abort = 1;
    tick();
    abort = 0;
    chk("ab_valid", valid, 0);
    chk("ab_busy", busy, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("ab_no_done", dones, 0);
    chk("ab_beats", beats, 20);
    q.delete();
    exp_done = 0;
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    chk("ab_start_valid", valid, 0);
    chk("ab_start_busy", busy, 0);
    start_job(3, 0, 1, 1, 1);
    run_until(30);
    rst = 1;
    start = 1;
    abort = 1;
    tick();
    chk("mr_valid", valid, 0);
    chk("mr_mask", mask, 0);
    chk("mr_row", row, 0);
    chk("mr_col", col, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    rst = 0;
    start = 0;
    abort = 0;
    q.delete();
    exp_done = 0;
    tick();
    chk("mr_idle_valid", valid, 0);
    chk("mr_no_done", dones, 0);
    start_job(7, 1, 2, 1, 1);
    wait_done(400);
    chk("post_rst_beats", beats, 256);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ita_mask_unit.md
ITA_MASK_UNIT -- requirements
Module: ita_mask_unit

Interface
REQ-001 SHALL have parameter N, default 16, mask lanes per beat (power of two).
REQ-002 SHALL have parameter M, default 64, tile edge (power of two, multiple of N).
REQ-003 SHALL have parameter WI, default 16, coordinate/config width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have ports start_i input 1 (job start pulse); abort_i input 1 (synchronous job abort).
REQ-007 SHALL have ports mode_i input 3 (mask mode); offset_i input WI (triangular offset / window size W); stride_log2_i input 4 (stride S=2^stride_log2_i).
REQ-008 SHALL have ports tile_s_i input WI (column tiles); tile_r_i input WI (row tiles).
REQ-009 SHALL have ports valid_o output 1; ready_i input 1; mask_o output N (bit i = lane i, 1 = masked); row_o output WI; col_o output WI (column of lane 0).
REQ-010 SHALL have ports busy_o output 1; done_o output 1 (single-cycle pulse).

Function
REQ-011 SHALL latch mode_i, offset_i, stride_log2_i, tile_s_i, tile_r_i on start_i in IDLE; start_i SHALL be ignored when not IDLE.
REQ-012 SHALL implement FSM IDLE -> RUN on start_i; RUN -> DRAIN after last beat generated; DRAIN -> IDLE on final handshake; any state -> IDLE on abort_i.
REQ-013 Beat order SHALL be: per tile, beat b = 0..M*M/N-1 with local row = b mod M, column group = b / M; tiles ordered tile_x inner (0..tile_s-1), tile_y outer (0..tile_r-1).
REQ-014 Coordinates SHALL be row = tile_y*M + (b mod M), col_i = tile_x*M + (b/M)*N + i; row_o = row, col_o = col_0.
REQ-015 Masking arithmetic SHALL use signed width WI+2, diff = col_i - row, no overflow for WI-bit inputs.
REQ-016 mode 0 None: all lanes 0.
REQ-017 mode 1 Upper: lane masked iff col_i > row + offset.
REQ-018 mode 2 Lower: lane masked iff col_i < row - offset.
REQ-019 mode 3 Strided: masked iff (diff mod S) != 0 (two's-complement low bits); S=1 masks nothing.
REQ-020 mode 4 UpperStrided: masked iff Strided condition or col_i < row; mode 5 LowerStrided: masked iff Strided condition or col_i > row.
REQ-021 mode 6 SlidingWindow: unmasked iff row-(W-1) <= col_i < row+W; W=0 masks all lanes.
REQ-022 mode 7 StridedSlidingWindow: unmasked iff Strided-unmasked or SlidingWindow-unmasked.
REQ-023 First valid_o SHALL rise exactly 1 cycle after accepted start_i.
REQ-024 mask_o/row_o/col_o SHALL be registered and held stable while valid_o=1 and ready_i=0.
REQ-025 Beat SHALL advance on valid_o&ready_i; with ready_i held 1, throughput SHALL be 1 beat/cycle with no bubbles.
REQ-026 Total beats per job SHALL be tile_r*tile_s*M*M/N; tile counters wrap tile_x to 0 and increment tile_y at tile_x = tile_s-1.
REQ-027 done_o SHALL pulse in the cycle after the final handshake; busy_o SHALL be 1 from the cycle after start accept until that done_o cycle, exclusive.
REQ-028 tile_s_i=0 or tile_r_i=0 SHALL produce no beats and done_o pulse 1 cycle after start.
REQ-029 abort_i SHALL clear valid_o next cycle, produce no done_o, and win over simultaneous start_i or handshake.
REQ-030 Config input changes during RUN SHALL have no effect on the running job.

Reset
REQ-031 rst_i SHALL force IDLE, valid_o=0, mask_o=0, row_o=0, col_o=0, busy_o=0, done_o=0, all counters 0, next cycle.
REQ-032 rst_i mid-job SHALL discard the job without done_o; rst_i SHALL override start_i and abort_i.

Verification (N=16, M=64, ready_i=1 unless stated)
REQ-033 mode 1, offset 0, 1x1 tiles: beat 0 -> mask_o=0xFFFE, row_o=0, col_o=0; beat 64 -> col_o=16, mask_o=0xFFFF; done_o after 256 beats.
REQ-034 mode 2, offset 0: beat 0 -> 0x0000; beat 5 (row 5) -> 0x001F.
REQ-035 mode 3, stride_log2 2: beat 0 -> 0xEEEE; beat 1 (row 1) -> 0xDDDD; mode 6, W=2: beat 0 -> 0xFFFC.
REQ-036 ready_i low 3 cycles at beat 10 -> valid_o=1, mask_o/row_o unchanged 3 cycles, beat 11 follows 1 cycle after ready_i rises.
REQ-037 tile_s=2, tile_r=2: 1024 beats, beat 256 -> row_o=0, col_o=64; beat 512 -> row_o=64, col_o=0; single done_o.
REQ-038 tile_s=0 -> done_o 1 cycle after start, valid_o never 1; abort_i at beat 20 -> valid_o=0 next cycle, no done_o; rst_i at beat 30 -> all outputs 0.
